// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer for the synchronous instruction ROM: PC, one-deep request tracking, 2-entry output queue.
// Optional halt detection is compiled in with `define HALT_DETECT_EN.
module instr_fetch_ctrl #(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [ADDR_W-1:0] PC_STEP   = ADDR_W'(4),
  parameter logic [31:0]       HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  output logic [ADDR_W-1:0] direccion,
  input  logic [31:0]       instruccion,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [31:0]       if_instr,
  output logic [ADDR_W-1:0] if_pc,
  output logic              halted,
  output logic [1:0]        dbg_state
);

`ifdef HALT_DETECT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1
`ifdef HALT_DETECT_EN
    , HALT = 2'd2
`endif
  } state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] pc_next;
  logic              pending;
  logic [ADDR_W-1:0] pending_addr;
  logic [31:0]       q_instr [2];
  logic [ADDR_W-1:0] q_pc    [2];
  logic [1:0]        count;
  logic [1:0]        occ;
  logic              push, pop, issue, halt_hit;
  logic [ADDR_W-1:0] redirect_aligned;

  // Handshake: an entry moves to IF/ID at a rising edge where if_valid && if_ready.
  assign if_valid         = (count != 2'd0);
  assign pop              = if_valid && if_ready;
  assign push             = pending && !redirect_valid;
  assign halt_hit         = HALT_EN && push && (instruccion == HALT_WORD);
  assign redirect_aligned = {redirect_pc[ADDR_W-1:2], 2'b00};

  // The head leaving this cycle frees its slot, which keeps delivery gap-free.
  assign occ   = count + {1'b0, pending} - {1'b0, pop};
  assign issue = (state == RUN) && enable && !redirect_valid && !halt_hit && (occ < 2'd2);

  assign if_instr  = if_valid ? q_instr[0] : '0;
  assign if_pc     = if_valid ? q_pc[0]    : '0;
  assign dbg_state = state;
`ifdef HALT_DETECT_EN
  assign halted    = (state == HALT);
`else
  assign halted    = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    if (redirect_valid) begin
      state_nx = enable ? RUN : IDLE;
    end
`ifdef HALT_DETECT_EN
    else if (halt_hit) begin
      state_nx = HALT;
    end
`endif
    else begin
      case (state)
        IDLE:    if (enable)  state_nx = RUN;
        RUN:     if (!enable) state_nx = IDLE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      direccion    <= RESET_PC;
      pc_next      <= RESET_PC + PC_STEP;
      pending      <= 1'b0;
      pending_addr <= '0;
    end else begin
      state   <= state_nx;
      pending <= issue;
      if (redirect_valid) begin
        direccion <= redirect_aligned;
        pc_next   <= redirect_aligned + PC_STEP;
      end else if (issue) begin
        pending_addr <= direccion;
        direccion    <= pc_next;
        pc_next      <= pc_next + PC_STEP;
      end
    end
  end

  // Shift queue: slot 0 is always the head.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count      <= '0;
      q_instr[0] <= '0;
      q_instr[1] <= '0;
      q_pc[0]    <= '0;
      q_pc[1]    <= '0;
    end else if (redirect_valid) begin
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            q_instr[0] <= instruccion;
            q_pc[0]    <= pending_addr;
          end else begin
            q_instr[1] <= instruccion;
            q_pc[1]    <= pending_addr;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          q_instr[0] <= q_instr[1];
          q_pc[0]    <= q_pc[1];
          count      <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            q_instr[0] <= instruccion;
            q_pc[0]    <= pending_addr;
          end else begin
            q_instr[0] <= q_instr[1];
            q_pc[0]    <= q_pc[1];
            q_instr[1] <= instruccion;
            q_pc[1]    <= pending_addr;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl: ROM model returns word index (addr>>2), optional halt word at 0xC.
module tb_instr_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] direccion;
  logic [31:0] instruccion;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        halted;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  bit halt_rom = 1'b0;

  logic [31:0] got_pc[$];
  logic [31:0] got_instr[$];
  logic [31:0] exp_q[$];

  instr_fetch_ctrl dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .direccion(direccion),
    .instruccion(instruccion), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .halted(halted), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    if (halt_rom && a == 32'hC) return 32'hFFFF_FFFF;
    return {2'b00, a[31:2]};
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) instruccion <= '0;
    else          instruccion <= rom_word(direccion);
  end

  // Records any handshake that will complete at the coming edge, then advances one cycle.
  task automatic tick();
    if (if_valid && if_ready) begin
      got_pc.push_back(if_pc);
      got_instr.push_back(if_instr);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0; enable = 1'b0; if_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    got_pc.delete(); got_instr.delete(); exp_q.delete();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; #1;
    checks++; if (direccion !== 32'h0) begin errors++; $display("FAIL reset_dir got %h want %h", direccion, 32'h0); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", if_valid); end
    checks++; if (if_instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %h want 0", if_instr); end
    checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want 0", if_pc); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b want 0", halted); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", dbg_state); end
    apply_reset();
    tick();
    checks++; if (direccion !== 32'h0) begin errors++; $display("FAIL idle_dir got %h want 0", direccion); end
  endtask

  task automatic test_stream();
    logic [31:0] e_dir;
    apply_reset();
    enable = 1'b1; if_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      e_dir = (k <= 1) ? 32'h0 : 32'((k - 1) * 4);
      checks++; if (direccion !== e_dir) begin errors++; $display("FAIL stream_dir%0d got %h want %h", k, direccion, e_dir); end
      checks++; if (if_valid !== (k >= 3)) begin errors++; $display("FAIL stream_valid%0d got %b want %b", k, if_valid, (k >= 3)); end
      if (k >= 3) begin
        checks++; if (if_pc !== 32'((k - 3) * 4)) begin errors++; $display("FAIL stream_pc%0d got %h want %h", k, if_pc, (k - 3) * 4); end
        checks++; if (if_instr !== 32'(k - 3)) begin errors++; $display("FAIL stream_instr%0d got %h want %h", k, if_instr, k - 3); end
      end
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    enable = 1'b1; if_ready = 1'b0;
    repeat (6) tick();
    checks++; if (direccion !== 32'h8) begin errors++; $display("FAIL bp_dir got %h want 8", direccion); end
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0) begin errors++; $display("FAIL bp_head got v%b pc %h want v1 pc 0", if_valid, if_pc); end
    if_ready = 1'b1;
    exp_q = '{32'h0, 32'h4, 32'h8, 32'hC};
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL bp_gap%0d got %b want 1", i, if_valid); end
    end
    checks++; if (got_pc.size() !== 4) begin errors++; $display("FAIL bp_count got %0d want 4", got_pc.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ((i < got_pc.size() ? got_pc[i] : 32'hx) !== exp_q[i] || (i < got_instr.size() ? got_instr[i] : 32'hx) !== (exp_q[i] >> 2)) begin
        errors++; $display("FAIL bp_word%0d got %h want %h", i, (i < got_pc.size() ? got_pc[i] : 32'hx), exp_q[i]);
      end
    end
  endtask

  task automatic test_redirect();
    apply_reset();
    enable = 1'b1; if_ready = 1'b0;
    repeat (5) tick();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0043;
    tick();
    redirect_valid = 1'b0;
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL redir_valid got %b want 0", if_valid); end
    checks++; if (direccion !== 32'h40) begin errors++; $display("FAIL redir_dir got %h want 40", direccion); end
    checks++; if (dbg_state !== 2'd1) begin errors++; $display("FAIL redir_state got %0d want 1", dbg_state); end
    if_ready = 1'b1;
    repeat (4) tick();
    exp_q = '{32'h40, 32'h44};
    checks++; if (got_pc.size() !== 2) begin errors++; $display("FAIL redir_count got %0d want 2", got_pc.size()); end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ((i < got_pc.size() ? got_pc[i] : 32'hx) !== exp_q[i] || (i < got_instr.size() ? got_instr[i] : 32'hx) !== (exp_q[i] >> 2)) begin
        errors++; $display("FAIL redir_word%0d got %h want %h", i, (i < got_pc.size() ? got_pc[i] : 32'hx), exp_q[i]);
      end
    end
  endtask

  task automatic test_redirect_wrap();
    logic [31:0] e_instr[3];
    apply_reset();
    enable = 1'b1; if_ready = 1'b1;
    repeat (4) tick();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    tick();
    redirect_valid = 1'b0;
    checks++; if (got_pc.size() !== 2 || got_pc[got_pc.size()-1] !== 32'h4) begin errors++; $display("FAIL wrap_popped got n%0d want last pc 4", got_pc.size()); end
    checks++; if (if_valid !== 1'b0 || direccion !== 32'hFFFF_FFF8) begin errors++; $display("FAIL wrap_dir got v%b %h want v0 fffffff8", if_valid, direccion); end
    got_pc.delete(); got_instr.delete();
    repeat (6) tick();
    exp_q = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0};
    e_instr = '{32'h3FFF_FFFE, 32'h3FFF_FFFF, 32'h0};
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ((i < got_pc.size() ? got_pc[i] : 32'hx) !== exp_q[i] || (i < got_instr.size() ? got_instr[i] : 32'hx) !== e_instr[i]) begin
        errors++; $display("FAIL wrap_word%0d got %h want %h", i, (i < got_pc.size() ? got_pc[i] : 32'hx), exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    enable = 1'b1; if_ready = 1'b1;
    repeat (5) tick();
    redirect_valid = 1'b1; redirect_pc = 32'h104;
    tick();
    redirect_pc = 32'h203;
    tick();
    redirect_valid = 1'b0;
    checks++; if (direccion !== 32'h200 || if_valid !== 1'b0) begin errors++; $display("FAIL b2b_dir got %h v%b want 200 v0", direccion, if_valid); end
    got_pc.delete(); got_instr.delete();
    repeat (4) tick();
    checks++; if (got_pc.size() !== 2) begin errors++; $display("FAIL b2b_count got %0d want 2", got_pc.size()); end
    checks++;
    if ((got_pc.size() > 0 ? got_pc[0] : 32'hx) !== 32'h200 || (got_instr.size() > 0 ? got_instr[0] : 32'hx) !== 32'h80) begin
      errors++; $display("FAIL b2b_first got %h want 200", (got_pc.size() > 0 ? got_pc[0] : 32'hx));
    end
  endtask

  task automatic test_enable_drop();
    apply_reset();
    enable = 1'b1; if_ready = 1'b1;
    repeat (6) tick();
    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (direccion !== 32'h14) begin errors++; $display("FAIL en_hold%0d got %h want 14", i, direccion); end
    end
    exp_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
    checks++; if (got_pc.size() !== 5) begin errors++; $display("FAIL en_count got %0d want 5", got_pc.size()); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ((i < got_pc.size() ? got_pc[i] : 32'hx) !== exp_q[i]) begin
        errors++; $display("FAIL en_word%0d got %h want %h", i, (i < got_pc.size() ? got_pc[i] : 32'hx), exp_q[i]);
      end
    end
    checks++; if (if_valid !== 1'b0 || dbg_state !== 2'd0) begin errors++; $display("FAIL en_idle got v%b s%0d want v0 s0", if_valid, dbg_state); end
    enable = 1'b1;
    repeat (4) tick();
    checks++;
    if (got_pc.size() !== 6 || got_pc[got_pc.size()-1] !== 32'h14 || got_instr[got_instr.size()-1] !== 32'h5) begin
      errors++; $display("FAIL en_resume got n%0d want 6 words ending at 14", got_pc.size());
    end
  endtask

  task automatic test_halt();
    halt_rom = 1'b1;
    apply_reset();
    enable = 1'b1; if_ready = 1'b1;
    repeat (10) tick();
`ifdef HALT_DETECT_EN
    exp_q = '{32'h0, 32'h4, 32'h8, 32'hC};
    checks++; if (halted !== 1'b1 || dbg_state !== 2'd2) begin errors++; $display("FAIL halt_flag got %b s%0d want 1 s2", halted, dbg_state); end
    checks++; if (direccion !== 32'h10) begin errors++; $display("FAIL halt_dir got %h want 10", direccion); end
`else
    exp_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h18};
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_flag got %b want 0", halted); end
`endif
    checks++; if (got_pc.size() !== exp_q.size()) begin errors++; $display("FAIL halt_count got %0d want %0d", got_pc.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if ((i < got_pc.size() ? got_pc[i] : 32'hx) !== exp_q[i]) begin
        errors++; $display("FAIL halt_word%0d got %h want %h", i, (i < got_pc.size() ? got_pc[i] : 32'hx), exp_q[i]);
      end
    end
    checks++; if ((got_instr.size() > 3 ? got_instr[3] : 32'hx) !== 32'hFFFF_FFFF) begin errors++; $display("FAIL halt_instr got %h want ffffffff", (got_instr.size() > 3 ? got_instr[3] : 32'hx)); end
    redirect_valid = 1'b1; redirect_pc = 32'h0;
    tick();
    redirect_valid = 1'b0;
    checks++; if (halted !== 1'b0 || direccion !== 32'h0) begin errors++; $display("FAIL halt_exit got h%b %h want h0 0", halted, direccion); end
    got_pc.delete(); got_instr.delete();
    repeat (4) tick();
    checks++; if ((got_pc.size() > 0 ? got_pc[0] : 32'hx) !== 32'h0 || got_pc.size() !== 2) begin errors++; $display("FAIL halt_resume got n%0d want 2 from pc 0", got_pc.size()); end
    halt_rom = 1'b0;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    enable = 1'b1; if_ready = 1'b1;
    repeat (5) tick();
    reset_n = 1'b0; #1;
    checks++; if (if_valid !== 1'b0 || if_pc !== 32'h0 || direccion !== 32'h0 || dbg_state !== 2'd0) begin
      errors++; $display("FAIL midreset got v%b pc %h dir %h s%0d want all 0", if_valid, if_pc, direccion, dbg_state);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    got_pc.delete(); got_instr.delete();
    repeat (4) tick();
    checks++; if (got_pc.size() !== 1 || got_pc[0] !== 32'h0) begin errors++; $display("FAIL midreset_resume got n%0d want 1 word at 0", got_pc.size()); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_wrap();
    test_back_to_back();
    test_enable_drop();
    test_halt();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
